jk_cmd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one JK flip-flop (2-bit `jk` command input, `q` output) among N_REQ requesters. Each requester presents a 2-bit JK command (HOLD/RESET/SET/TOGGLE). The block grants one requester at a time, drives the command onto the flop for exactly one cycle, samples the updated `q` and returns it with a one-cycle acknowledge. It sits between the requesting logic and the JK flip-flop, and is the only driver of the flop's `jk` input.

---
 rtl/jk_cmd_arbiter.sv | 130 +++++++++++++
 tb/tb_jk_cmd_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter that shares one JK flip-flop among N_REQ requesters.
// Each transaction grants one requester, issues its command for one cycle, then returns q with an ack.
module jk_cmd_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   cmd,
    input  logic                 q_in,
    output logic [1:0]           jk_out,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic                 q_rsp,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ISSUE  = 2'b01,
        ST_SAMPLE = 2'b10
    } state_t;

    state_t             state_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   gidx_r;
    logic [PTR_W-1:0]   ptr_nxt_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic               win_vld_s;
    logic [1:0]         win_cmd_s;
    logic [N_REQ-1:0]   win_onehot_s;

    // Round-robin search: first active request at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        int idx_v;
        idx_v     = 0;
        win_idx_s = '0;
        win_vld_s = 1'b0;
        // Scan from lowest to highest priority so the highest-priority hit is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_v = (int'(ptr_r) + k) % N_REQ;
            if (((req >> idx_v) & N_REQ'(1)) != '0) begin
                win_idx_s = PTR_W'(idx_v);
                win_vld_s = 1'b1;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Select the winner's command and build its one-hot grant vector.
    always_comb begin
        win_cmd_s    = 2'b00;
        win_onehot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx_s == PTR_W'(i)) begin
                win_cmd_s       = cmd[2*i +: 2];
                win_onehot_s[i] = 1'b1;
            end else begin
                win_cmd_s = win_cmd_s;
            end
        end
    end

    // Pointer moves just past the served requester so it becomes lowest priority.
    always_comb begin
        if (gidx_r == PTR_W'(N_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gidx_r + PTR_W'(1);
        end
    end

    // Transaction sequencer; every output is registered and cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            gidx_r  <= '0;
            grant   <= '0;
            ack     <= '0;
            jk_out  <= 2'b00;
            q_rsp   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack <= '0;
                    if (win_vld_s) begin
                        // jk_out doubles as the command latch for the ISSUE cycle.
                        grant   <= win_onehot_s;
                        gidx_r  <= win_idx_s;
                        jk_out  <= win_cmd_s;
                        busy    <= 1'b1;
                        state_r <= ST_ISSUE;
                    end else begin
                        grant   <= '0;
                        jk_out  <= 2'b00;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    jk_out  <= 2'b00;
                    ack     <= '0;
                    state_r <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    // q_in already reflects the flop update made at the end of ISSUE.
                    ack     <= grant;
                    q_rsp   <= q_in;
                    ptr_r   <= ptr_nxt_s;
                    grant   <= '0;
                    jk_out  <= 2'b00;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    grant   <= '0;
                    ack     <= '0;
                    jk_out  <= 2'b00;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Randomized and directed bench for jk_cmd_arbiter against a timeline-level reference model.
// The bench also models the shared JK flip-flop that jk_out drives and q_in reads back.
module tb_jk_cmd_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] cmd = 8'h00;
    logic       q_in;
    logic [1:0] jk_out;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       q_rsp;
    logic       busy;
    logic       q_flop = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: cycles since the last grant edge (0 = no transaction).
    int         since = 0;
    int         ptr = 0;
    int         g = 0;
    logic [1:0] gcmd = 2'b00;
    logic       ref_q = 1'b0;
    logic       exp_q_rsp = 1'b0;

    jk_cmd_arbiter #(.N_REQ(4), .PTR_W(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .cmd    (cmd),
        .q_in   (q_in),
        .jk_out (jk_out),
        .grant  (grant),
        .ack    (ack),
        .q_rsp  (q_rsp),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic jk_next(input logic q, input logic [1:0] c);
        case (c)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    // Shared JK flip-flop; its own reset is never asserted.
    assign q_in = q_flop;
    always @(posedge clk) q_flop <= jk_next(q_flop, jk_out);

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        since     = 0;
        ptr       = 0;
        exp_q_rsp = 1'b0;
    endtask

    // Advance the reference model across one rising edge using the inputs held before it.
    task automatic model_edge();
        bit found;
        found = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (since == 1) begin
            ref_q = jk_next(ref_q, gcmd);
            since = 2;
        end else if (since == 2) begin
            exp_q_rsp = ref_q;
            ptr   = (g + 1) % N;
            since = 3;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (req[i] && !found) begin
                    found = 1'b1;
                    g     = i;
                    gcmd  = cmd[2*i +: 2];
                end
            end
            since = found ? 1 : 0;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] exp_g;
        logic [3:0] exp_a;
        exp_g = (since == 1 || since == 2) ? (4'b0001 << g) : 4'b0000;
        exp_a = (since == 3) ? (4'b0001 << g) : 4'b0000;
        chk_eq("grant",  32'(grant),  32'(exp_g));
        chk_eq("ack",    32'(ack),    32'(exp_a));
        chk_eq("jk_out", 32'(jk_out), 32'((since == 1) ? gcmd : 2'b00));
        chk_eq("busy",   32'(busy),   32'(since == 1 || since == 2));
        chk_eq("q_rsp",  32'(q_rsp),  32'(exp_q_rsp));
        chk_eq("q_flop", 32'(q_flop), 32'(ref_q));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // One isolated transaction: request for one edge, then let it complete.
    task automatic txn(input logic [3:0] r, input logic [7:0] c);
        req = r;
        cmd = c;
        cycle();
        req = 4'b0000;
        repeat (4) cycle();
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset held with all requests pending.
        req = 4'b1111;
        cmd = 8'b11_10_01_00;
        #2;
        assert_reset();
        repeat (3) cycle();
        rst = 1'b1;

        // Fairness with all requesters active, then with requester 1 dropped.
        repeat (13) cycle();
        req = 4'b1101;
        repeat (13) cycle();
        req = 4'b0000;
        repeat (4) cycle();

        // Clear q, then a single SET from requester 2.
        txn(4'b0001, 8'b00_00_00_01);
        txn(4'b0100, 8'b00_10_00_00);

        // Request withdrawn during ISSUE: RESET from requester 3 must still complete.
        txn(4'b1000, 8'b01_00_00_00);

        // Four TOGGLEs from requester 1 starting at q=0.
        repeat (4) txn(4'b0010, 8'b00_00_11_00);

        // Reset during ISSUE of requester 2, then check arbitration restarts at requester 0.
        req = 4'b0100;
        cmd = 8'b00_11_00_00;
        cycle();
        req = 4'b0000;
        assert_reset();
        repeat (2) cycle();
        rst = 1'b1;
        req = 4'b1111;
        cmd = 8'b10_01_11_10;
        repeat (6) cycle();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                assert_reset();
                cycle();
                rst = 1'b1;
            end
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            cmd = 8'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
